// File: rtl/board_io_pkg.sv
// Shared constants and elaboration helpers for the board I/O conditioner.
// Optional auto-repeat is enabled with the BOARD_IO_REPEAT_EN macro.
package board_io_pkg;

  localparam int unsigned DefaultChannels       = 4;
  localparam int unsigned DefaultSyncStages     = 2;
  localparam int unsigned DefaultDebounceCycles = 16;
  localparam int unsigned DefaultRepeatDelay    = 1024;
  localparam int unsigned DefaultRepeatPeriod   = 256;

  // Counter width able to hold values 0..value-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  function automatic bit channels_ok(input int unsigned channels);
    return (channels >= 1) && (channels <= 64);
  endfunction

  function automatic bit channel_params_ok(input int unsigned sync_stages,
                                           input int unsigned repeat_delay,
                                           input int unsigned repeat_period);
    return (sync_stages >= 2) && (repeat_delay >= 1) && (repeat_period >= 1);
  endfunction

endpackage

// File: rtl/board_io_channel.sv
// One conditioned input: inversion, synchroniser, debounce, edge pulses and
// (with BOARD_IO_REPEAT_EN) auto-repeat press pulses.
module board_io_channel
  import board_io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DefaultSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = DefaultRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefaultRepeatPeriod
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic press
);

  if (!channel_params_ok(SYNC_STAGES, REPEAT_DELAY, REPEAT_PERIOD)) begin : g_bad_params
    $error("board_io_channel: SYNC_STAGES must be >= 2, REPEAT_* must be >= 1");
  end

  logic                   norm;
  logic                   synced;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d, level_q;
  logic                   rise_q, fall_q;

  assign norm   = raw ^ ACTIVE_LOW;
  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], norm};
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign level_d = synced;
  end else begin : g_debounce
    localparam int unsigned    CntW    = cnt_width(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    logic [CntW-1:0] cnt_q;

    // Any sample matching the current level restarts the count from zero.
    always_ff @(posedge clock) begin
      if (reset)                                   cnt_q <= '0;
      else if (synced == level_q || cnt_q == CntLast) cnt_q <= '0;
      else                                         cnt_q <= cnt_q + 1'b1;
    end

    assign level_d = (synced != level_q && cnt_q == CntLast) ? synced : level_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef BOARD_IO_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = cnt_width(RepMax + 1);
  localparam logic [RepW-1:0] RepDelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepPeriodLast = RepW'(REPEAT_PERIOD - 1);

  logic [RepW-1:0] rep_q;
  logic            press_q;

  // Down-counter to the next repeat; only runs while the level stays high.
  always_ff @(posedge clock) begin
    if (reset) begin
      rep_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (level_d && !level_q) begin
        rep_q   <= RepDelayLast;
        press_q <= 1'b1;
      end else if (!level_d) begin
        rep_q <= '0;
      end else if (rep_q == '0) begin
        rep_q   <= RepPeriodLast;
        press_q <= 1'b1;
      end else begin
        rep_q <= rep_q - 1'b1;
      end
    end
  end

  assign press = press_q;
`else
  assign press = rise_q;
`endif

endmodule

// File: rtl/board_io_conditioner.sv
// Multi-channel button/switch front-end: one board_io_channel per input plus a
// registered any-change flag. Auto-repeat is enabled with BOARD_IO_REPEAT_EN.
module board_io_conditioner
  import board_io_pkg::*;
#(
  parameter int unsigned          CHANNELS        = DefaultChannels,
  parameter int unsigned          SYNC_STAGES     = DefaultSyncStages,
  parameter int unsigned          DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter logic [CHANNELS-1:0]  ACTIVE_LOW_MASK = '1,
  parameter int unsigned          REPEAT_DELAY    = DefaultRepeatDelay,
  parameter int unsigned          REPEAT_PERIOD   = DefaultRepeatPeriod
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] press_pulse,
  output logic                any_change
);

  if (!channels_ok(CHANNELS)) begin : g_bad_channels
    $error("board_io_conditioner: CHANNELS must be in 1..64");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    board_io_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW_MASK[i]),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clock(clock),
      .reset(reset),
      .raw  (raw_in[i]),
      .level(level_out[i]),
      .rise (rise_pulse[i]),
      .fall (fall_pulse[i]),
      .press(press_pulse[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) any_change <= 1'b0;
    else       any_change <= |(rise_pulse | fall_pulse);
  end

endmodule

// File: tb/tb_board_io_conditioner.sv
// Self-checking bench: directed scenarios plus random stimulus, all checked
// against a window-based behavioural model of the conditioner.
module tb_board_io_conditioner;

  localparam int S  = 2;
  localparam int DC = 8;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int HL = S + DC - 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] raw_in = 4'hF;
  logic [3:0] level_out, rise_pulse, fall_pulse, press_pulse;
  logic       any_change;

  int tests_run = 0;
  int tests_failed = 0;

  board_io_conditioner #(
    .CHANNELS       (4),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW_MASK(4'hF),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .raw_in     (raw_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .press_pulse(press_pulse),
    .any_change (any_change)
  );

  always #5 clock = ~clock;

  // Reference model: hist[a] holds the active-high input sampled a+1 edges ago.
  // A level flips when every sample in the last DC synchronised cycles disagrees.
  logic [3:0]  hist [HL];
  logic [3:0]  m_level = '0, m_rise = '0, m_fall = '0, m_press = '0;
  logic        m_any = 1'b0;
  int unsigned m_age [4];
  logic [3:0]  m_nl;
  bit          m_flip;

  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < HL; k++) hist[k] = '0;
      m_level = '0; m_rise = '0; m_fall = '0; m_press = '0; m_any = 1'b0;
      for (int i = 0; i < 4; i++) m_age[i] = 0;
    end else begin
      m_any = |(m_rise | m_fall);
      m_nl  = m_level;
      for (int i = 0; i < 4; i++) begin
        m_flip = 1'b1;
        for (int k = S - 1; k < HL; k++) if (hist[k][i] == m_level[i]) m_flip = 1'b0;
        if (m_flip) m_nl[i] = ~m_level[i];
      end
      m_rise = m_nl & ~m_level;
      m_fall = ~m_nl & m_level;
      for (int i = 0; i < 4; i++) begin
        if (m_rise[i]) begin
          m_age[i]   = 0;
          m_press[i] = 1'b1;
        end else if (m_nl[i]) begin
          m_age[i]++;
`ifdef BOARD_IO_REPEAT_EN
          m_press[i] = (m_age[i] == RD) || (m_age[i] > RD && (m_age[i] - RD) % RP == 0);
`else
          m_press[i] = 1'b0;
`endif
        end else begin
          m_press[i] = 1'b0;
        end
      end
      m_level = m_nl;
      for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = raw_in ^ 4'hF;
    end
  end

  function automatic logic [16:0] dut_vec();
    return {level_out, rise_pulse, fall_pulse, press_pulse, any_change};
  endfunction

  function automatic logic [16:0] model_vec();
    return {m_level, m_rise, m_fall, m_press, m_any};
  endfunction

  task automatic test_reset();
    reset  = 1'b1;
    raw_in = 4'hF;
    repeat (5) begin
      @(negedge clock);
      tests_run++;
      if (dut_vec() !== 17'h0) begin
        tests_failed++;
        $display("FAIL reset_hold: outputs %h, required 0", dut_vec());
      end
    end
    reset = 1'b0;
    repeat (50) begin
      @(negedge clock);
      tests_run++;
      if (dut_vec() !== 17'h0) begin
        tests_failed++;
        $display("FAIL reset_idle: outputs %h, required 0", dut_vec());
      end
    end
  endtask

  task automatic test_press_release();
    raw_in[0] = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clock);
      tests_run++;
      if (level_out[0] !== (k >= 10) || rise_pulse[0] !== (k == 10) ||
          any_change !== (k == 11) || dut_vec() !== model_vec()) begin
        tests_failed++;
        $display("FAIL press k=%0d: dut %h model %h", k, dut_vec(), model_vec());
      end
    end
    raw_in[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      tests_run++;
      if (level_out[0] !== (k < 10) || fall_pulse[0] !== (k == 10) ||
          any_change !== (k == 11) || dut_vec() !== model_vec()) begin
        tests_failed++;
        $display("FAIL release k=%0d: dut %h model %h", k, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_bounce();
    for (int t = 0; t < 21; t++) begin
      raw_in[1] = ~raw_in[1];
      repeat (3) begin
        @(negedge clock);
        tests_run++;
        if ((rise_pulse | fall_pulse) !== 4'h0 || dut_vec() !== model_vec()) begin
          tests_failed++;
          $display("FAIL bounce: pulses %h dut %h model %h", rise_pulse | fall_pulse,
                   dut_vec(), model_vec());
        end
      end
    end
    // Last toggle left raw_in[1] low and it is now held; 3 edges already passed.
    for (int k = 4; k <= 14; k++) begin
      @(negedge clock);
      tests_run++;
      if (rise_pulse !== ((k == 10) ? 4'b0010 : 4'b0000) || dut_vec() !== model_vec()) begin
        tests_failed++;
        $display("FAIL bounce_settle k=%0d: rise %h dut %h model %h", k, rise_pulse,
                 dut_vec(), model_vec());
      end
    end
    raw_in[1] = 1'b1;
    repeat (15) @(negedge clock);
  endtask

  task automatic test_simultaneous();
    raw_in[3:2] = 2'b00;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      tests_run++;
      if (rise_pulse !== ((k == 10) ? 4'b1100 : 4'b0000) || level_out[1:0] !== 2'b00 ||
          dut_vec() !== model_vec()) begin
        tests_failed++;
        $display("FAIL simultaneous k=%0d: dut %h model %h", k, dut_vec(), model_vec());
      end
    end
    raw_in[3:2] = 2'b11;
    repeat (15) @(negedge clock);
  endtask

  task automatic test_reset_mid_debounce();
    raw_in[0] = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      tests_run++;
      if (dut_vec() !== 17'h0) begin
        tests_failed++;
        $display("FAIL reset_mid_hold: outputs %h, required 0", dut_vec());
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      tests_run++;
      if (level_out[0] !== (k >= 10) || rise_pulse[0] !== (k == 10) ||
          dut_vec() !== model_vec()) begin
        tests_failed++;
        $display("FAIL reset_mid k=%0d: dut %h model %h", k, dut_vec(), model_vec());
      end
    end
    raw_in[0] = 1'b1;
    repeat (15) @(negedge clock);
  endtask

  task automatic test_repeat();
    logic exp_press;
    raw_in[2] = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clock);
`ifdef BOARD_IO_REPEAT_EN
      exp_press = (k == 10) || (k == 30) || (k == 35) || (k == 40) || (k == 45);
`else
      exp_press = (k == 10);
`endif
      tests_run++;
      if (press_pulse[2] !== exp_press || fall_pulse[2] !== (k == 49) ||
          dut_vec() !== model_vec()) begin
        tests_failed++;
        $display("FAIL repeat k=%0d: press %b required %b, dut %h model %h", k,
                 press_pulse[2], exp_press, dut_vec(), model_vec());
      end
      if (k == 39) raw_in[2] = 1'b1;
    end
  endtask

  task automatic test_random();
    int hold;
    for (int n = 0; n < 60; n++) begin
      raw_in = 4'($urandom);
      hold = $urandom_range(1, 15);
      repeat (hold) begin
        @(negedge clock);
        tests_run++;
        if (dut_vec() !== model_vec()) begin
          tests_failed++;
          $display("FAIL random: dut %h model %h", dut_vec(), model_vec());
        end
      end
    end
    raw_in = 4'hF;
    repeat (20) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    test_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
